// File: rtl/mmio_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_fifo_pkg
// Purpose  : Shared definitions for the MMIO FIFO bank: register offsets
//            within a channel window, STATUS bit positions, the packed
//            STATUS word and a helper that assembles it.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mmio_fifo_pkg;

  // Register offsets inside one channel window (32-bit-word units)
  localparam int OFS_DATA  = 0;
  localparam int OFS_STAT  = 2;
  localparam int OFS_CTRL  = 4;
  localparam int CH_STRIDE = 8;

  // STATUS bit positions
  localparam int STAT_COUNT_LSB = 0;
  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_UFLOW_BIT = 18;
  localparam int STAT_DROP_LSB  = 32;

  // CONTROL bit positions
  localparam int CTRL_FLUSH_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  // Field order (MSB first) lines up with the bit positions above
  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [15:0] drop_cnt;
    logic [12:0] rsvd_lo;
    logic        underflow;
    logic        full;
    logic        empty;
    logic [15:0] count;
  } t_fifo_status;

  function automatic t_fifo_status make_status(
    input logic [15:0] count,
    input logic        empty,
    input logic        full,
    input logic        underflow,
    input logic [15:0] drop_cnt
  );
    t_fifo_status s;
    s           = '0;
    s.count     = count;
    s.empty     = empty;
    s.full      = full;
    s.underflow = underflow;
    s.drop_cnt  = drop_cnt;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_fifo_ch.sv
`default_nettype none
// ============================================================================
// Module   : mmio_fifo_ch
// Purpose  : One circular-buffer FIFO channel with sticky underflow flag and
//            saturating drop counter.
// Ports    : clk, rst_n (sync active-low)
//            push/pop/flush/clr strobes, din          - requests
//            head, count, empty, full                 - FIFO state
//            underflow, drop_cnt                      - error bookkeeping
// Revision : 1.0 - initial release
// ============================================================================
module mmio_fifo_ch #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              underflow,
  output logic [15:0]       drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_pop;
  logic              do_push;
  logic              drop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign head  = mem[rd_ptr];

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  // Storage needs no reset: contents are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underflow <= 1'b0;
      drop_cnt  <= '0;
    end else if (clr) begin
      underflow <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (pop && empty) underflow <= 1'b1;
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmio_fifo_bank.sv
`default_nettype none
// ============================================================================
// Module   : mmio_fifo_bank
// Purpose  : Bank of NUM_CH MMIO-mapped FIFOs. Each channel window holds
//            DATA (write pushes, read pops), STATUS (read) and CONTROL
//            (write: flush / clear). Read hits are answered one cycle later.
// Ports    : clk, rst_n (sync active-low)
//            mmio_wr, mmio_rd, mmio_addr, mmio_tid, mmio_wdata - request
//            rsp_valid, rsp_tid, rsp_data                      - response
//            ch_empty, ch_full                                 - per-channel flags
// Revision : 1.0 - initial release
// ============================================================================
module mmio_fifo_bank
  import mmio_fifo_pkg::*;
#(
  parameter int                NUM_CH    = 4,
  parameter int                DEPTH     = 8,
  parameter int                DATA_W    = 64,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h0020,
  parameter int                TID_W     = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mmio_wr,
  input  logic              mmio_rd,
  input  logic [ADDR_W-1:0] mmio_addr,
  input  logic [TID_W-1:0]  mmio_tid,
  input  logic [63:0]       mmio_wdata,
  output logic              rsp_valid,
  output logic [TID_W-1:0]  rsp_tid,
  output logic [63:0]       rsp_data,
  output logic [NUM_CH-1:0] ch_empty,
  output logic [NUM_CH-1:0] ch_full
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] off;
  logic              hit;
  logic [2:0]        sub;
  logic [NUM_CH-1:0] sel;
  logic              rd_hit;
  logic [63:0]       rd_word;

  logic [DATA_W-1:0] head      [NUM_CH];
  logic [CNT_W-1:0]  count     [NUM_CH];
  logic [15:0]       drop_cnt  [NUM_CH];
  logic [NUM_CH-1:0] underflow;
  t_fifo_status      stat      [NUM_CH];

  // Window-relative address; the lower-bound test keeps wrapped
  // subtraction results below BASE_ADDR from aliasing into the window.
  assign off = mmio_addr - BASE_ADDR;
  assign hit = (mmio_addr >= BASE_ADDR) &&
               (off < ADDR_W'(NUM_CH * CH_STRIDE));
  assign sub = off[2:0];

  // Reads to CONTROL or unmapped offsets are left for the AFU to answer
  assign rd_hit = mmio_rd && hit &&
                  ((sub == 3'(OFS_DATA)) || (sub == 3'(OFS_STAT)));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic push;
    logic pop;
    logic flush;
    logic clr;

    assign sel[c] = hit && (off[ADDR_W-1:3] == (ADDR_W-3)'(c));
    assign push   = mmio_wr && sel[c] && (sub == 3'(OFS_DATA));
    assign pop    = mmio_rd && sel[c] && (sub == 3'(OFS_DATA));
    assign flush  = mmio_wr && sel[c] && (sub == 3'(OFS_CTRL)) &&
                    mmio_wdata[CTRL_FLUSH_BIT];
    assign clr    = mmio_wr && sel[c] && (sub == 3'(OFS_CTRL)) &&
                    mmio_wdata[CTRL_CLEAR_BIT];

    mmio_fifo_ch #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .flush     (flush),
      .clr       (clr),
      .din       (mmio_wdata[DATA_W-1:0]),
      .head      (head[c]),
      .count     (count[c]),
      .empty     (ch_empty[c]),
      .full      (ch_full[c]),
      .underflow (underflow[c]),
      .drop_cnt  (drop_cnt[c])
    );

    assign stat[c] = make_status(16'(count[c]), ch_empty[c], ch_full[c],
                                 underflow[c], drop_cnt[c]);
  end

  // Read mux sees pre-access state, so pops return the old head and
  // STATUS ignores any same-cycle write.
  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel[c]) begin
        if (sub == 3'(OFS_DATA)) begin
          rd_word = ch_empty[c] ? 64'd0 : 64'(head[c]);
        end else begin
          rd_word = stat[c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_tid   <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= rd_hit;
      if (rd_hit) begin
        rsp_tid  <= mmio_tid;
        rsp_data <= rd_word;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_fifo_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_fifo_bank
// Purpose  : Directed self-checking bench for mmio_fifo_bank with a
//            queue-based reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_fifo_bank;

  localparam int          NCH   = 4;
  localparam int          DEPTH = 8;
  localparam logic [15:0] BASE  = 16'h0020;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mmio_wr = 1'b0;
  logic        mmio_rd = 1'b0;
  logic [15:0] mmio_addr = '0;
  logic [8:0]  mmio_tid = '0;
  logic [63:0] mmio_wdata = '0;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic [3:0]  ch_empty;
  logic [3:0]  ch_full;

  mmio_fifo_bank #(
    .NUM_CH(NCH), .DEPTH(DEPTH), .DATA_W(64), .ADDR_W(16),
    .BASE_ADDR(BASE), .TID_W(9)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wdata(mmio_wdata),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
    .ch_empty(ch_empty), .ch_full(ch_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [63:0] mq [NCH][$];
  bit          m_uf   [NCH];
  int          m_drop [NCH];
  logic        m_valid = 1'b0;
  logic [8:0]  m_tid   = '0;
  logic [63:0] m_data  = '0;
  bit          m_hit;
  int          m_ch;
  int          m_off;

  function automatic logic [63:0] status_of(input int c);
    int sz;
    sz = mq[c].size();
    return 64'(sz) | (64'(sz == 0) << 16) | (64'(sz == DEPTH) << 17) |
           (64'(m_uf[c]) << 18) | (64'(m_drop[c]) << 32);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        mq[c].delete();
        m_uf[c]   = 1'b0;
        m_drop[c] = 0;
      end
      m_valid = 1'b0;
      m_tid   = '0;
      m_data  = '0;
    end else begin
      m_hit = (mmio_addr >= BASE) && (int'(mmio_addr) < int'(BASE) + 8 * NCH);
      m_ch  = m_hit ? (int'(mmio_addr) - int'(BASE)) / 8 : 0;
      m_off = m_hit ? (int'(mmio_addr) - int'(BASE)) % 8 : 7;
      m_valid = 1'b0;
      // reads observe the state before this cycle's writes
      if (m_hit && mmio_rd && (m_off == 0 || m_off == 2)) begin
        m_valid = 1'b1;
        m_tid   = mmio_tid;
        if (m_off == 0) m_data = (mq[m_ch].size() > 0) ? mq[m_ch][0] : 64'h0;
        else            m_data = status_of(m_ch);
      end
      if (m_hit && mmio_rd && m_off == 0) begin
        if (mq[m_ch].size() > 0) void'(mq[m_ch].pop_front());
        else m_uf[m_ch] = 1'b1;
      end
      if (m_hit && mmio_wr && m_off == 0) begin
        if (mq[m_ch].size() < DEPTH) mq[m_ch].push_back(mmio_wdata);
        else if (m_drop[m_ch] < 65535) m_drop[m_ch]++;
      end
      if (m_hit && mmio_wr && m_off == 4) begin
        if (mmio_wdata[0]) mq[m_ch].delete();
        if (mmio_wdata[1]) begin
          m_drop[m_ch] = 0;
          m_uf[m_ch]   = 1'b0;
        end
      end
    end
  end

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    logic [3:0] e_empty;
    logic [3:0] e_full;
    if (chk_en) begin
      for (int c = 0; c < NCH; c++) begin
        e_empty[c] = (mq[c].size() == 0);
        e_full[c]  = (mq[c].size() == DEPTH);
      end
      chk("cyc_rsp_valid", 64'(rsp_valid), 64'(m_valid));
      chk("cyc_rsp_tid",   64'(rsp_tid),   64'(m_tid));
      chk("cyc_rsp_data",  rsp_data,       m_data);
      chk("cyc_ch_empty",  64'(ch_empty),  64'(e_empty));
      chk("cyc_ch_full",   64'(ch_full),   64'(e_full));
    end
  end

  // ---------------- stimulus ----------------
  logic [8:0] tid_ctr = 9'h011;

  task automatic op(input logic w, input logic r, input logic [15:0] a, input logic [63:0] d);
    mmio_wr    = w;
    mmio_rd    = r;
    mmio_addr  = a;
    mmio_wdata = d;
    mmio_tid   = tid_ctr;
    tid_ctr    = tid_ctr + 9'd1;
    @(posedge clk);
    @(negedge clk);
    mmio_wr = 1'b0;
    mmio_rd = 1'b0;
  endtask

  task automatic rd_expect(input string nm, input logic [15:0] a, input logic [63:0] exp);
    op(1'b0, 1'b1, a, 64'h0);
    chk({nm, "_valid"}, 64'(rsp_valid), 64'h1);
    chk(nm, rsp_data, exp);
  endtask

  initial begin
    logic [8:0] t0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    chk("reset_empty", 64'(ch_empty), 64'hF);
    chk("reset_full",  64'(ch_full),  64'h0);
    chk("reset_valid", 64'(rsp_valid), 64'h0);
    chk("reset_data",  rsp_data, 64'h0);

    // ch0 STATUS after reset, tid echoed
    t0 = tid_ctr;
    rd_expect("ch0_stat_reset", 16'h0022, 64'h0000_0000_0001_0000);
    chk("ch0_stat_tid", 64'(rsp_tid), 64'(t0));

    // ch1 in-order pops
    for (int i = 0; i < 3; i++) op(1'b1, 1'b0, 16'h0028, 64'hA1 + 64'(i));
    rd_expect("ch1_stat3", 16'h002A, 64'h0000_0000_0000_0003);
    rd_expect("ch1_pop0", 16'h0028, 64'hA1);
    rd_expect("ch1_pop1", 16'h0028, 64'hA2);
    rd_expect("ch1_pop2", 16'h0028, 64'hA3);
    rd_expect("ch1_stat0", 16'h002A, 64'h0000_0000_0001_0000);

    // ch2 overflow and drop counter clear
    for (int i = 0; i < 11; i++) op(1'b1, 1'b0, 16'h0030, 64'h200 + 64'(i));
    rd_expect("ch2_stat_full", 16'h0032, 64'h0000_0003_0002_0008);
    op(1'b1, 1'b0, 16'h0034, 64'h2);
    rd_expect("ch2_stat_clr", 16'h0032, 64'h0000_0000_0002_0008);

    // ch3 underflow is sticky until cleared
    rd_expect("ch3_pop_empty", 16'h0038, 64'h0);
    rd_expect("ch3_stat_uf", 16'h003A, 64'h0000_0000_0005_0000);
    op(1'b1, 1'b0, 16'h0038, 64'h55);
    rd_expect("ch3_pop55", 16'h0038, 64'h55);
    rd_expect("ch3_stat_uf2", 16'h003A, 64'h0000_0000_0005_0000);
    op(1'b1, 1'b0, 16'h003C, 64'h2);
    rd_expect("ch3_stat_clr", 16'h003A, 64'h0000_0000_0001_0000);

    // ch0 full, same-cycle push + pop
    for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 16'h0020, 64'h100 + 64'(i));
    op(1'b1, 1'b1, 16'h0020, 64'hBB);
    chk("ch0_pp_data", rsp_data, 64'h100);
    rd_expect("ch0_pp_stat", 16'h0022, 64'h0000_0000_0002_0008);
    for (int i = 1; i < 8; i++) rd_expect("ch0_drain", 16'h0020, 64'h100 + 64'(i));
    rd_expect("ch0_last_bb", 16'h0020, 64'hBB);

    // unmapped accesses: no response
    op(1'b1, 1'b0, 16'h0040, 64'h99);
    op(1'b0, 1'b1, 16'h0040, 64'h0);
    chk("miss_0040_valid", 64'(rsp_valid), 64'h0);
    op(1'b0, 1'b1, 16'h0024, 64'h0);
    chk("miss_ctrl_valid", 64'(rsp_valid), 64'h0);
    op(1'b0, 1'b1, 16'h001E, 64'h0);
    chk("miss_low_valid", 64'(rsp_valid), 64'h0);

    // flush
    op(1'b1, 1'b0, 16'h0028, 64'h7);
    op(1'b1, 1'b0, 16'h0028, 64'h8);
    op(1'b1, 1'b0, 16'h002C, 64'h1);
    rd_expect("ch1_flushed", 16'h002A, 64'h0000_0000_0001_0000);

    // pointer wrap
    for (int i = 0; i < 20; i++) begin
      op(1'b1, 1'b0, 16'h0028, 64'h300 + 64'(i));
      rd_expect("ch1_wrap", 16'h0028, 64'h300 + 64'(i));
    end

    // reset the cycle after a read
    op(1'b1, 1'b0, 16'h0020, 64'h77);
    mmio_rd   = 1'b1;
    mmio_addr = 16'h0020;
    @(posedge clk);
    @(negedge clk);
    mmio_rd = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_after_rd_valid", 64'(rsp_valid), 64'h0);
    chk("rst_after_rd_empty", 64'(ch_empty), 64'hF);
    @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
